// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the MEM-stage sequencer (master) and the pipeline/data-memory side (slave).
// Handshake: dmem_read/dmem_write and their address/lanes/data stay steady until the one-cycle dmem_resp pulse.
interface mem_stage_ctrl_if;
  logic        mem_valid;
  logic        mem_read;
  logic        mem_write;
  logic        mem_indirect;
  logic [1:0]  mem_byte_sig;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_wdata;
  logic        stall;
  logic        done;
  logic [15:0] load_data;

  modport master (
    input  mem_valid, mem_read, mem_write, mem_indirect, mem_byte_sig,
           mem_address, mem_wdata, dmem_rdata, dmem_resp,
    output dmem_address, dmem_read, dmem_write, dmem_byte_enable,
           dmem_wdata, stall, done, load_data
  );

  modport slave (
    output mem_valid, mem_read, mem_write, mem_indirect, mem_byte_sig,
           mem_address, mem_wdata, dmem_rdata, dmem_resp,
    input  dmem_address, dmem_read, dmem_write, dmem_byte_enable,
           dmem_wdata, stall, done, load_data
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage access sequencer: one data-memory access at a time, LDI/STI pointer fetch,
// byte-lane steering, pipeline stall and a saturating stall-cycle counter.
module mem_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_stage_ctrl_if.master bus,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE, IND_PTR, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] load_q;
  logic        write_q;
  logic        byte_q;
  logic        req;
  logic        stall_c;
  logic        done_c;
  logic        rd_c;
  logic        wr_c;
  logic [1:0]  be_c;
  logic [15:0] addr_c;
  logic [15:0] wdata_c;

  // A request with both read and write set is treated as a write.
  assign req = bus.mem_valid & (bus.mem_read | bus.mem_write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_q      <= '0;
      write_q     <= 1'b0;
      byte_q      <= 1'b0;
      stall_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) begin
        addr_q  <= bus.mem_address;
        wdata_q <= bus.mem_wdata;
        write_q <= bus.mem_write;
        byte_q  <= (bus.mem_byte_sig == 2'b01);
      end
      // The fetched pointer replaces the address used by the real access.
      if (state_q == IND_PTR && bus.dmem_resp)
        addr_q <= bus.dmem_rdata;
      if (state_q == ACCESS && bus.dmem_resp && !write_q) begin
        if (byte_q)
          load_q <= {8'h00, (addr_q[0] ? bus.dmem_rdata[15:8] : bus.dmem_rdata[7:0])};
        else
          load_q <= bus.dmem_rdata;
      end
      if (stall_c && stall_count != {CNT_W{1'b1}})
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    done_c  = 1'b0;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    be_c    = 2'b00;
    addr_c  = 16'h0000;
    wdata_c = 16'h0000;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          state_d = bus.mem_indirect ? IND_PTR : ACCESS;
        end
      end
      IND_PTR: begin
        stall_c = 1'b1;
        rd_c    = 1'b1;
        addr_c  = {addr_q[15:1], 1'b0};
        be_c    = 2'b11;
        if (bus.dmem_resp) state_d = ACCESS;
      end
      ACCESS: begin
        stall_c = 1'b1;
        rd_c    = ~write_q;
        wr_c    = write_q;
        if (byte_q) begin
          addr_c  = addr_q;
          be_c    = addr_q[0] ? 2'b10 : 2'b01;
          wdata_c = {wdata_q[7:0], wdata_q[7:0]};
        end else begin
          addr_c  = {addr_q[15:1], 1'b0};
          be_c    = 2'b11;
          wdata_c = wdata_q;
        end
        if (bus.dmem_resp) state_d = DONE;
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dmem_address     = addr_c;
  assign bus.dmem_read        = rd_c;
  assign bus.dmem_write       = wr_c;
  assign bus.dmem_byte_enable = be_c;
  assign bus.dmem_wdata       = wdata_c;
  assign bus.stall            = stall_c;
  assign bus.done             = done_c;
  assign bus.load_data        = load_q;
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: word/byte loads and stores, LDI, reset during STI,
// read+write priority, ignored responses and stall-counter saturation.
module tb_mem_stage_ctrl;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state_dbg;
  int               vectors = 0;
  int               miscompares = 0;
  int               rd_done_cnt = 0;
  int               wr_issue_cnt = 0;
  int               rd_before;
  int               wr_before;

  always #5 clk = ~clk;

  mem_stage_ctrl_if bus();

  mem_stage_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .stall_count (stall_count),
    .state_dbg   (state_dbg)
  );

  // Completed reads and any issued write strobe, seen at the clock edge.
  always @(posedge clk) begin
    if (bus.dmem_read && bus.dmem_resp) rd_done_cnt <= rd_done_cnt + 1;
    if (bus.dmem_write) wr_issue_cnt <= wr_issue_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_valid    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_indirect = 1'b0;
    bus.mem_byte_sig = 2'b00;
    bus.mem_address  = 16'h0000;
    bus.mem_wdata    = 16'h0000;
    bus.dmem_rdata   = 16'h0000;
    bus.dmem_resp    = 1'b0;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic ind,
                           input logic [1:0] bs, input logic [15:0] a, input logic [15:0] wd);
    bus.mem_valid    = 1'b1;
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.mem_indirect = ind;
    bus.mem_byte_sig = bs;
    bus.mem_address  = a;
    bus.mem_wdata    = wd;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 16'(state_dbg), 16'h0);
    chk("rst_stall", 16'(bus.stall), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_read", 16'(bus.dmem_read), 16'h0);
    chk("rst_write", 16'(bus.dmem_write), 16'h0);
    chk("rst_be", 16'(bus.dmem_byte_enable), 16'h0);
    chk("rst_addr", bus.dmem_address, 16'h0000);
    chk("rst_wdata", bus.dmem_wdata, 16'h0000);
    chk("rst_load", bus.load_data, 16'h0000);
    chk("rst_count", stall_count, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // Word LDR at 0x1235, memory answers on the first ACCESS cycle
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 2'b00, 16'h1235, 16'h0000);
    #1;
    chk("ldr_idle_stall", 16'(bus.stall), 16'h1);
    chk("ldr_idle_read", 16'(bus.dmem_read), 16'h0);
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'hBEEF;
    #1;
    chk("ldr_addr", bus.dmem_address, 16'h1234);
    chk("ldr_be", 16'(bus.dmem_byte_enable), 16'h3);
    chk("ldr_read", 16'(bus.dmem_read), 16'h1);
    chk("ldr_stall", 16'(bus.stall), 16'h1);
    chk("ldr_state", 16'(state_dbg), 16'h2);
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("ldr_done", 16'(bus.done), 16'h1);
    chk("ldr_done_stall", 16'(bus.stall), 16'h0);
    chk("ldr_load", bus.load_data, 16'hBEEF);
    chk("ldr_count", stall_count, 16'd2);
    chk("ldr_done_read", 16'(bus.dmem_read), 16'h0);
    @(negedge clk);
    #1;
    chk("ldr_after_done", 16'(bus.done), 16'h0);
    chk("ldr_after_state", 16'(state_dbg), 16'h0);

    // STB at 0x2001, memory latency 3
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b0, 2'b01, 16'h2001, 16'h00A5);
    #1;
    chk("stb_idle_stall", 16'(bus.stall), 16'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.dmem_resp = (k == 2);
      #1;
      chk($sformatf("stb_write%0d", k), 16'(bus.dmem_write), 16'h1);
      chk($sformatf("stb_be%0d", k), 16'(bus.dmem_byte_enable), 16'h2);
      chk($sformatf("stb_wdata%0d", k), bus.dmem_wdata, 16'hA5A5);
      chk($sformatf("stb_addr%0d", k), bus.dmem_address, 16'h2001);
    end
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("stb_done", 16'(bus.done), 16'h1);
    chk("stb_done_write", 16'(bus.dmem_write), 16'h0);
    chk("stb_load_kept", bus.load_data, 16'hBEEF);
    chk("stb_count", stall_count, 16'd6);
    @(negedge clk);

    // LDB at 0x3000 (low lane)
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 2'b01, 16'h3000, 16'h0000);
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h12F0;
    #1;
    chk("ldb_lo_be", 16'(bus.dmem_byte_enable), 16'h1);
    chk("ldb_lo_addr", bus.dmem_address, 16'h3000);
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("ldb_lo_done", 16'(bus.done), 16'h1);
    chk("ldb_lo_load", bus.load_data, 16'h00F0);
    chk("ldb_lo_count", stall_count, 16'd8);
    @(negedge clk);

    // LDB at 0x3001 (high lane)
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 2'b01, 16'h3001, 16'h0000);
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h12F0;
    #1;
    chk("ldb_hi_be", 16'(bus.dmem_byte_enable), 16'h2);
    chk("ldb_hi_addr", bus.dmem_address, 16'h3001);
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("ldb_hi_load", bus.load_data, 16'h0012);
    chk("ldb_hi_count", stall_count, 16'd10);
    @(negedge clk);

    // LDI at 0x4000: pointer 0x5002, data 0x7777
    rd_before = rd_done_cnt;
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b1, 2'b00, 16'h4000, 16'h0000);
    #1;
    chk("ldi_idle_stall", 16'(bus.stall), 16'h1);
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h5002;
    #1;
    chk("ldi_ptr_state", 16'(state_dbg), 16'h1);
    chk("ldi_ptr_addr", bus.dmem_address, 16'h4000);
    chk("ldi_ptr_read", 16'(bus.dmem_read), 16'h1);
    chk("ldi_ptr_be", 16'(bus.dmem_byte_enable), 16'h3);
    @(negedge clk);
    bus.dmem_rdata = 16'h7777;
    #1;
    chk("ldi_acc_state", 16'(state_dbg), 16'h2);
    chk("ldi_acc_addr", bus.dmem_address, 16'h5002);
    chk("ldi_acc_read", 16'(bus.dmem_read), 16'h1);
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("ldi_done", 16'(bus.done), 16'h1);
    chk("ldi_load", bus.load_data, 16'h7777);
    chk("ldi_count", stall_count, 16'd13);
    chk("ldi_reads", 16'(rd_done_cnt - rd_before), 16'd2);
    @(negedge clk);

    // dmem_resp while idle must not disturb anything
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    #1;
    chk("idle_resp_load", bus.load_data, 16'h7777);
    chk("idle_resp_state", 16'(state_dbg), 16'h0);
    chk("idle_resp_count", stall_count, 16'd13);

    // Read and write both set: a word store
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, 2'b00, 16'h0011, 16'h1357);
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h9999;
    #1;
    chk("rw_write", 16'(bus.dmem_write), 16'h1);
    chk("rw_read", 16'(bus.dmem_read), 16'h0);
    chk("rw_addr", bus.dmem_address, 16'h0010);
    chk("rw_wdata", bus.dmem_wdata, 16'h1357);
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("rw_done", 16'(bus.done), 16'h1);
    chk("rw_load_kept", bus.load_data, 16'h7777);
    chk("rw_count", stall_count, 16'd15);
    @(negedge clk);

    // STI with reset during the pointer wait
    wr_before = wr_issue_cnt;
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 2'b00, 16'h6000, 16'hAAAA);
    @(negedge clk);
    #1;
    chk("sti_ptr_state", 16'(state_dbg), 16'h1);
    chk("sti_ptr_read", 16'(bus.dmem_read), 16'h1);
    @(negedge clk);
    #1;
    reset_n       = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("sti_rst_state", 16'(state_dbg), 16'h0);
    chk("sti_rst_stall", 16'(bus.stall), 16'h0);
    chk("sti_rst_read", 16'(bus.dmem_read), 16'h0);
    chk("sti_rst_addr", bus.dmem_address, 16'h0000);
    chk("sti_rst_be", 16'(bus.dmem_byte_enable), 16'h0);
    chk("sti_rst_load", bus.load_data, 16'h0000);
    chk("sti_rst_count", stall_count, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h6100;
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    #1;
    chk("sti_after_state", 16'(state_dbg), 16'h0);
    chk("sti_no_write", 16'(wr_issue_cnt - wr_before), 16'd0);
    chk("sti_after_load", bus.load_data, 16'h0000);
    chk("sti_after_done", 16'(bus.done), 16'h0);

    // Stall counter saturation with a memory that does not answer
    @(negedge clk);
    drive_req(1'b1, 1'b0, 1'b0, 2'b00, 16'h8000, 16'h0000);
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_fffe", stall_count, 16'hFFFE);
    @(negedge clk);
    #1;
    chk("sat_ffff", stall_count, 16'hFFFF);
    repeat (5) @(negedge clk);
    #1;
    chk("sat_hold", stall_count, 16'hFFFF);
    chk("sat_stall", 16'(bus.stall), 16'h1);
    @(negedge clk);
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h4242;
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    chk("sat_done", 16'(bus.done), 16'h1);
    chk("sat_load", bus.load_data, 16'h4242);
    chk("sat_final", stall_count, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences data-memory accesses for the MEM stage of the LC-3b pipeline.
- Converts the decoded MEM controls (read, write, indirect, byte size) into a one-access-at-a-time handshake with the data memory.
- Runs the two-access sequence for LDI/STI, steers byte lanes, and stalls the pipeline until the access completes.
- Keeps a saturating count of stall cycles for performance debug.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_read  in  1  decoded load
- mem_write  in  1  decoded store
- mem_indirect  in  1  LDI/STI: the address points to a word holding the effective address
- mem_byte_sig  in  2  2'b01 selects a byte access; any other value selects a word access
- mem_address  in  16  ALU-computed address
- mem_wdata  in  16  store data (SR)
- dmem_rdata  in  16  memory read data
- dmem_resp  in  1  memory completion, one-cycle pulse
- dmem_address  out  16  memory address
- dmem_read  out  1  read strobe
- dmem_write  out  1  write strobe
- dmem_byte_enable  out  2  lane enables, [1] is the high byte
- dmem_wdata  out  16  memory write data
- stall  out  1  freeze IF through MEM
- done  out  1  one-cycle pulse: access complete
- load_data  out  16  load result, valid while done=1
- stall_count  out  CNT_W  saturating count of cycles with stall=1

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state goes to IDLE.
  - Outputs: dmem_read, dmem_write, stall, done = 0; dmem_byte_enable = 0; dmem_address, dmem_wdata, load_data, stall_count = 0.
  - Reset in mid-operation abandons the access immediately; a dmem_resp arriving after reset is ignored.
- Request: req = mem_valid & (mem_read | mem_write). mem_read and mem_write both set is illegal; treat it as a write.
- States: IDLE, IND_PTR, ACCESS, DONE.
  - IDLE: on req, latch address, wdata, write flag, byte flag and indirect flag. Next state is IND_PTR if indirect, else ACCESS. stall=1 in this cycle (combinational on req). No req: stay in IDLE, stall=0.
  - IND_PTR:
    - dmem_read=1, dmem_address = {addr[15:1],0}, byte_enable = 2'b11.
    - On dmem_resp: latch ptr = dmem_rdata, go to ACCESS using ptr as the address.
    - The pointer fetch is always a word access.
  - ACCESS: drive the strobe for the latched read or write. Strobes are held steady until dmem_resp.
    - Word access: dmem_address = {a[15:1],0}; byte_enable = 2'b11; dmem_wdata = wdata.
    - Byte access: dmem_address = a; byte_enable = a[0] ? 2'b10 : 2'b01; dmem_wdata = {wdata[7:0], wdata[7:0]}.
    - On dmem_resp:
      - Word read: load_data = dmem_rdata.
      - Byte read: load_data = zero-extended dmem_rdata[15:8] if a[0]=1, else zero-extended dmem_rdata[7:0].
      - Then go to DONE.
  - DONE: done=1, stall=0, no strobes. The pipeline advances on this edge. Next state is IDLE. A new req in the following cycle starts a new access.
- stall = 1 in IND_PTR and ACCESS, and in IDLE when req=1. Otherwise 0.
- Latency, with memory responding N≥1 cycles after the strobe:
  - Direct access: stall for 1+N cycles, done in cycle 2+N.
  - Indirect access: stall for 1+N1+N2 cycles, where N1 and N2 are the two access latencies.
- dmem_resp in IDLE or DONE is ignored.
- load_data holds its value until the next load completes. Stores leave it unchanged.
- stall_count increments on every clock with stall=1 and saturates at all-ones (no wrap).

Test Plan:
- Word LDR at mem_address=0x1235, memory returns 0xBEEF on the first ACCESS cycle:
  - dmem_address=0x1234, byte_enable=2'b11, dmem_read=1.
  - stall high for 2 cycles, then done=1 with load_data=0xBEEF; stall_count=2.
- STB at 0x2001 with mem_wdata=0x00A5, memory latency 3:
  - dmem_write=1, byte_enable=2'b10, dmem_wdata=0xA5A5, address=0x2001.
  - Strobes held for 3 cycles; done on the 5th cycle.
- LDB at 0x3000 returning 0x12F0: byte_enable=2'b01; load_data=0x00F0.
- LDI at 0x4000, pointer read returns 0x5002, second read returns 0x7777:
  - First read has address 0x4000; second read has address 0x5002.
  - load_data=0x7777; exactly 2 dmem_read accesses.
- STI with reset_n pulsed low during the IND_PTR wait:
  - All outputs clear immediately; a subsequent dmem_resp has no effect.
  - No dmem_write ever issues; state is IDLE.
- Back-to-back req for 2^CNT_W cycles with slow memory:
  - stall_count stops at all-ones (0xFFFF for the default CNT_W) and does not wrap.
